// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and parameter legality check for the MAC multiplier.
// Revision : 1.0
// ============================================================================
package mult_pkg;

    typedef struct packed {
        logic signed_a;
        logic signed_b;
    } mult_mode_t;

    // Operand width must be a power of two (>= 4) split evenly across stages.
    function automatic bit mult_params_ok(input int data_width, input int depth);
        if (data_width < 4)
            return 1'b0;
        if ((data_width & (data_width - 1)) != 0)
            return 1'b0;
        if (depth < 1)
            return 1'b0;
        return (data_width % depth) == 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_array_multiplier_stage.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_multiplier_stage
// Purpose  : Combinational slice of the array multiplier retiring a group of
//            multiplier bits; the last slice also applies sign correction.
// Revision : 1.0
// ============================================================================
module mac_array_multiplier_stage
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PIPELINE_DEPTH = 8,
    parameter int STAGE          = 0
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  mult_mode_t            i_mode,
    input  logic [DATA_WIDTH-1:0] i_psum,
    input  logic [DATA_WIDTH-1:0] i_lo,
    output logic [DATA_WIDTH-1:0] o_psum,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int PRODUCT_PER_STAGE = DATA_WIDTH / PIPELINE_DEPTH;
    localparam bit c_LAST            = (STAGE == PIPELINE_DEPTH - 1);

    logic [DATA_WIDTH-1:0] w_hi;
    logic [DATA_WIDTH-1:0] w_lo;
    logic [DATA_WIDTH:0]   w_row;
    logic [DATA_WIDTH-1:0] w_bsel;
    logic [DATA_WIDTH-1:0] w_corr;

    // Unsigned shift-add rows, then a Baugh-Wooley style correction of the
    // upper half: ext(A)*ext(B) = A*B - 2^W*(sa*a_msb*B + sb*b_msb*A) mod 2^2W.
    always_comb begin
        w_hi   = i_psum;
        w_lo   = i_lo;
        w_row  = '0;
        w_bsel = i_b >> (STAGE * PRODUCT_PER_STAGE);
        for (int r = 0; r < PRODUCT_PER_STAGE; r++) begin
            w_row  = {1'b0, w_hi} + (w_bsel[0] ? {1'b0, i_a} : '0);
            w_lo   = {w_row[0], w_lo[DATA_WIDTH-1:1]};
            w_hi   = w_row[DATA_WIDTH:1];
            w_bsel = w_bsel >> 1;
        end
        w_corr = ((i_mode.signed_a && i_a[DATA_WIDTH-1]) ? i_b : '0)
               + ((i_mode.signed_b && i_b[DATA_WIDTH-1]) ? i_a : '0);
        o_psum = c_LAST ? (w_hi - w_corr) : w_hi;
        o_lo   = w_lo;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_mac_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_mac_array_multiplier
// Purpose  : Elastic pipelined array multiplier with tag sideband and a single
//            global advance (stall) signal.
// Revision : 1.0
// ============================================================================
module pipelined_mac_array_multiplier
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PIPELINE_DEPTH = 8,
    parameter int TAG_WIDTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [DATA_WIDTH-1:0]     multiplicand_i,
    input  logic [DATA_WIDTH-1:0]     multiplier_i,
    input  logic                      signed_a_i,
    input  logic                      signed_b_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [2*DATA_WIDTH-1:0]   product_o,
    output logic [TAG_WIDTH-1:0]      tag_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    if (!mult_params_ok(DATA_WIDTH, PIPELINE_DEPTH)) begin : g_param_check
        $error("pipelined_mac_array_multiplier: illegal DATA_WIDTH/PIPELINE_DEPTH");
    end

    // w_st_* are the values entering stage i (ports for stage 0).
    logic [DATA_WIDTH-1:0]     w_st_a    [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]     w_st_b    [PIPELINE_DEPTH];
    mult_mode_t                w_st_mode [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]     w_st_psum [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]     w_st_lo   [PIPELINE_DEPTH];
    logic [TAG_WIDTH-1:0]      w_st_tag  [PIPELINE_DEPTH];
    logic [PIPELINE_DEPTH-1:0] w_st_vld;
    logic [DATA_WIDTH-1:0]     w_nx_psum [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]     w_nx_lo   [PIPELINE_DEPTH];
    logic [PIPELINE_DEPTH-1:0] w_reg_vld;
    logic                      w_advance;

    assign w_advance = !valid_o || ready_i;
    assign ready_o   = w_advance;
    assign busy_o    = |w_reg_vld;

    assign w_st_a[0]    = multiplicand_i;
    assign w_st_b[0]    = multiplier_i;
    assign w_st_mode[0] = '{signed_a: signed_a_i, signed_b: signed_b_i};
    assign w_st_psum[0] = '0;
    assign w_st_lo[0]   = '0;
    assign w_st_tag[0]  = tag_i;
    assign w_st_vld[0]  = valid_i;

    for (genvar gi = 0; gi < PIPELINE_DEPTH; gi++) begin : g_stage
        mac_array_multiplier_stage #(
            .DATA_WIDTH     (DATA_WIDTH),
            .PIPELINE_DEPTH (PIPELINE_DEPTH),
            .STAGE          (gi)
        ) u_stage (
            .i_a    (w_st_a[gi]),
            .i_b    (w_st_b[gi]),
            .i_mode (w_st_mode[gi]),
            .i_psum (w_st_psum[gi]),
            .i_lo   (w_st_lo[gi]),
            .o_psum (w_nx_psum[gi]),
            .o_lo   (w_nx_lo[gi])
        );

        if (gi < PIPELINE_DEPTH - 1) begin : g_mid
            logic [DATA_WIDTH-1:0] r_a;
            logic [DATA_WIDTH-1:0] r_b;
            mult_mode_t            r_mode;
            logic [DATA_WIDTH-1:0] r_psum;
            logic [DATA_WIDTH-1:0] r_lo;
            logic [TAG_WIDTH-1:0]  r_tag;
            logic                  r_vld;

            always_ff @(posedge clk_i) begin
                if (rst_i)
                    r_vld <= 1'b0;
                else if (w_advance)
                    r_vld <= w_st_vld[gi];
            end

            // Data only loads with a valid op, so bubbles never pull in X.
            always_ff @(posedge clk_i) begin
                if (w_advance && w_st_vld[gi]) begin
                    r_a    <= w_st_a[gi];
                    r_b    <= w_st_b[gi];
                    r_mode <= w_st_mode[gi];
                    r_psum <= w_nx_psum[gi];
                    r_lo   <= w_nx_lo[gi];
                    r_tag  <= w_st_tag[gi];
                end
            end

            assign w_st_a[gi+1]    = r_a;
            assign w_st_b[gi+1]    = r_b;
            assign w_st_mode[gi+1] = r_mode;
            assign w_st_psum[gi+1] = r_psum;
            assign w_st_lo[gi+1]   = r_lo;
            assign w_st_tag[gi+1]  = r_tag;
            assign w_st_vld[gi+1]  = r_vld;
            assign w_reg_vld[gi]   = r_vld;
        end else begin : g_last
            logic [DATA_WIDTH-1:0] r_hi;
            logic [DATA_WIDTH-1:0] r_lo;
            logic [TAG_WIDTH-1:0]  r_tag;
            logic                  r_vld;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_vld <= 1'b0;
                    r_hi  <= '0;
                    r_lo  <= '0;
                    r_tag <= '0;
                end else if (w_advance) begin
                    r_vld <= w_st_vld[gi];
                    if (w_st_vld[gi]) begin
                        r_hi  <= w_nx_psum[gi];
                        r_lo  <= w_nx_lo[gi];
                        r_tag <= w_st_tag[gi];
                    end
                end
            end

            assign product_o     = {r_hi, r_lo};
            assign tag_o         = r_tag;
            assign valid_o       = r_vld;
            assign w_reg_vld[gi] = r_vld;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_mac_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_mac_array_multiplier
// Purpose  : Self-checking bench with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_pipelined_mac_array_multiplier;

    localparam int c_W = 32;
    localparam int c_D = 8;
    localparam int c_T = 4;

    logic               clk = 1'b0;
    logic               rst_i;
    logic [c_W-1:0]     multiplicand_i;
    logic [c_W-1:0]     multiplier_i;
    logic               signed_a_i;
    logic               signed_b_i;
    logic [c_T-1:0]     tag_i;
    logic               valid_i;
    logic               ready_o;
    logic [2*c_W-1:0]   product_o;
    logic [c_T-1:0]     tag_o;
    logic               valid_o;
    logic               ready_i;
    logic               busy_o;

    typedef struct {
        logic [63:0] prod;
        logic [3:0]  tag;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en     = 1'b0;
    bit          lat_chk_en = 1'b0;
    bit          rand_ready = 1'b0;
    bit          head_seen  = 1'b0;
    bit          stalled    = 1'b0;
    logic [63:0] stall_prod;
    logic [3:0]  stall_tag;

    pipelined_mac_array_multiplier #(
        .DATA_WIDTH     (c_W),
        .PIPELINE_DEPTH (c_D),
        .TAG_WIDTH      (c_T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .signed_a_i     (signed_a_i),
        .signed_b_i     (signed_b_i),
        .tag_i          (tag_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .product_o      (product_o),
        .tag_o          (tag_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard / protocol monitor, sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                chk("busy", 64'(busy_o), 64'(q.size() != 0));
                chk("ready_rule", 64'(ready_o), 64'(!(valid_o && !ready_i)));
                if (q.size() == 0)
                    chk("idle_valid", 64'(valid_o), 64'(0));
                if (stalled) begin
                    chk("stall_valid", 64'(valid_o), 64'(1));
                    chk("stall_prod", product_o, stall_prod);
                    chk("stall_tag", 64'(tag_o), 64'(stall_tag));
                end
                stalled    = valid_o && !ready_i;
                stall_prod = product_o;
                stall_tag  = tag_o;
                if (valid_o && q.size() != 0) begin
                    if (!head_seen) begin
                        head_seen = 1'b1;
                        if (lat_chk_en)
                            chk("latency", 64'(cyc - q[0].acc_cyc), 64'(c_D));
                    end
                    if (ready_i) begin
                        e = q.pop_front();
                        head_seen = 1'b0;
                        chk("product", product_o, e.prod);
                        chk("tag", 64'(tag_o), 64'(e.tag));
                    end
                end
                if (rst_i) begin
                    q.delete();
                    head_seen = 1'b0;
                    stalled   = 1'b0;
                end else if (valid_i && ready_o) begin
                    e.prod    = model(multiplicand_i, multiplier_i, signed_a_i, signed_b_i);
                    e.tag     = tag_i;
                    e.acc_cyc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Random downstream back-pressure, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready)
                ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sa, input logic sb, input logic [3:0] t);
        int   n;
        logic acc;
        multiplicand_i = a;
        multiplier_i   = b;
        signed_a_i     = sa;
        signed_b_i     = sb;
        tag_i          = t;
        valid_i        = 1'b1;
        acc            = 1'b0;
        n              = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accept", 64'(acc), 64'(1));
    endtask

    // Single op with ready_i held high: checks exact latency and a fixed value.
    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic sa,
                            input logic sb, input logic [3:0] t, input logic [63:0] exp);
        send(a, b, sa, sb, t);
        valid_i = 1'b0;
        repeat (c_D - 2) @(posedge clk);
        @(negedge clk);
        chk("dir_not_early", 64'(valid_o), 64'(0));
        @(negedge clk);
        chk("dir_valid", 64'(valid_o), 64'(1));
        chk("dir_product", product_o, exp);
        chk("dir_tag", 64'(tag_o), 64'(t));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        valid_i = 1'b0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    initial begin
        rst_i          = 1'b1;
        valid_i        = 1'b0;
        ready_i        = 1'b1;
        multiplicand_i = '0;
        multiplier_i   = '0;
        signed_a_i     = 1'b0;
        signed_b_i     = 1'b0;
        tag_i          = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_ready", 64'(ready_o), 64'(1));
        chk("rst_product", product_o, 64'(0));
        chk("rst_tag", 64'(tag_o), 64'(0));
        @(posedge clk);
        #1;
        mon_en     = 1'b1;
        lat_chk_en = 1'b1;

        directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd3, 64'hFFFF_FFFE_0000_0001);
        directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd4, 64'h0000_0000_0000_0001);
        directed(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd5, 64'h4000_0000_0000_0000);
        directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd6, 64'hFFFF_FFFF_0000_0001);
        directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd7, 64'hFFFF_FFFF_0000_0001);

        // Bubble pattern 1,0,1,0,1 must reappear unchanged on the output.
        for (int k = 0; k < 5; k++) begin
            valid_i        = (k % 2 == 0);
            multiplicand_i = $urandom;
            multiplier_i   = $urandom;
            signed_a_i     = 1'($urandom_range(0, 1));
            signed_b_i     = 1'($urandom_range(0, 1));
            tag_i          = 4'(k + 8);
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        repeat (c_D - 5) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bubble_valid", 64'(valid_o), 64'(k % 2 == 0));
            if (valid_o)
                chk("bubble_tag", 64'(tag_o), 64'(k + 8));
        end
        @(posedge clk);
        #1;
        drain();

        // Back-to-back random ops, free flowing, all sign modes.
        for (int k = 0; k < 30; k++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(k));
        drain();

        // Back-to-back random ops under random back-pressure.
        lat_chk_en = 1'b0;
        rand_ready = 1'b1;
        for (int k = 0; k < 20; k++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(k));
        valid_i    = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rand_ready = 1'b0;
        ready_i    = 1'b1;
        drain();
        lat_chk_en = 1'b1;

        // Reset while operations are in flight: nothing may emerge afterwards.
        for (int k = 0; k < 5; k++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(k + 1));
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(valid_o), 64'(0));
            chk("post_rst_busy", 64'(busy_o), 64'(0));
        end
        @(posedge clk);
        #1;
        directed(32'd7, 32'd6, 1'b0, 1'b0, 4'd9, 64'd42);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
